// File: rtl/pong_match_ctrl.sv
// Match sequencer for the Pong panel: start -> serve countdown -> rally -> point hold -> game over.
// Latency: all outputs registered; score change freezes play 1 cycle later, start edge to clear 3 cycles.
// Backpressure: none; countdowns advance only on frame_tick, events outside their states are dropped.
module pong_match_ctrl #(
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int WIN_SCORE    = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       pause,
  input  logic [5:0] p1_score,
  input  logic [5:0] p2_score,
  output logic       play_enable,
  output logic       panel_clr,
  output logic [2:0] state,
  output logic [7:0] countdown,
  output logic [1:0] winner,
  output logic       game_over
);

  localparam logic [7:0] SERVE_LOAD = 8'(SERVE_FRAMES);
  localparam logic [7:0] POINT_LOAD = 8'(POINT_FRAMES);
  localparam logic [5:0] WIN_LEVEL  = 6'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_SERVE  = 3'd2,
    S_PLAY   = 3'd3,
    S_POINT  = 3'd4,
    S_PAUSED = 3'd5,
    S_OVER   = 3'd6
  } state_t;

  state_t     cur_state;
  state_t     nxt_state;
  logic [7:0] cnt_nxt;
  logic [1:0] win_nxt;
  logic [5:0] p1_snap;
  logic [5:0] p2_snap;
  logic [5:0] p1_snap_nxt;
  logic [5:0] p2_snap_nxt;
  logic       play_en_nxt;
  logic       clr_nxt;
  logic       over_nxt;

  logic       start_s0;
  logic       start_s1;
  logic       start_edge;
  logic       start_rise;

  logic       score_chg;
  logic       p1_win;
  logic       p2_win;

  // Bring the raw start button into the clock domain and remember the last synced level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      start_s0   <= 1'b0;
      start_s1   <= 1'b0;
      start_edge <= 1'b0;
    end else begin
      start_s0   <= start;
      start_s1   <= start_s0;
      start_edge <= start_s1;
    end
  end

  // A held button yields a single rise; it must drop before it can start again.
  assign start_rise = start_s1 & ~start_edge;

  // Any difference from the snapshot counts as a point, including a decrease.
  assign score_chg = (p1_score != p1_snap) || (p2_score != p2_snap);
  assign p1_win    = (p1_score >= WIN_LEVEL);
  assign p2_win    = (p2_score >= WIN_LEVEL);

  // Next-state, countdown, snapshot and output decode for the match sequence.
  always_comb begin
    nxt_state   = cur_state;
    cnt_nxt     = countdown;
    win_nxt     = winner;
    p1_snap_nxt = p1_snap;
    p2_snap_nxt = p2_snap;

    case (cur_state)
      S_IDLE, S_OVER: begin
        if (start_rise) begin
          nxt_state   = S_CLEAR;
          win_nxt     = 2'b00;
          p1_snap_nxt = 6'd0;
          p2_snap_nxt = 6'd0;
          cnt_nxt     = 8'd0;
        end
      end

      S_CLEAR: begin
        nxt_state = S_SERVE;
        cnt_nxt   = SERVE_LOAD;
      end

      S_SERVE: begin
        if (frame_tick) begin
          if (countdown <= 8'd1) begin
            nxt_state = S_PLAY;
            cnt_nxt   = 8'd0;
          end else begin
            cnt_nxt = countdown - 8'd1;
          end
        end
      end

      S_PLAY: begin
        // A point outranks a pause request raised in the same cycle.
        if (score_chg) begin
          p1_snap_nxt = p1_score;
          p2_snap_nxt = p2_score;
          if (p1_win || p2_win) begin
            nxt_state = S_OVER;
            win_nxt   = {p2_win, p1_win};
          end else begin
            nxt_state = S_POINT;
            cnt_nxt   = POINT_LOAD;
          end
        end else if (pause) begin
          nxt_state = S_PAUSED;
        end
      end

      S_POINT: begin
        if (frame_tick) begin
          if (countdown <= 8'd1) begin
            nxt_state = S_SERVE;
            cnt_nxt   = SERVE_LOAD;
          end else begin
            cnt_nxt = countdown - 8'd1;
          end
        end
      end

      S_PAUSED: begin
        // Panel is frozen here, so scores are left for PLAY to pick up.
        if (!pause) begin
          nxt_state = S_PLAY;
        end
      end

      default: begin
        nxt_state = S_IDLE;
        cnt_nxt   = 8'd0;
        win_nxt   = 2'b00;
      end
    endcase

    play_en_nxt = (nxt_state == S_PLAY);
    clr_nxt     = (nxt_state == S_CLEAR);
    over_nxt    = (nxt_state == S_OVER);
  end

  // State, counters and all outputs register together so they change on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_state   <= S_IDLE;
      countdown   <= 8'd0;
      winner      <= 2'b00;
      p1_snap     <= 6'd0;
      p2_snap     <= 6'd0;
      play_enable <= 1'b0;
      panel_clr   <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      cur_state   <= nxt_state;
      countdown   <= cnt_nxt;
      winner      <= win_nxt;
      p1_snap     <= p1_snap_nxt;
      p2_snap     <= p2_snap_nxt;
      play_enable <= play_en_nxt;
      panel_clr   <= clr_nxt;
      game_over   <= over_nxt;
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: directed match scenarios followed by randomized play.
// Every cycle the DUT outputs are compared with a procedural match model.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_pong_match_ctrl;

  localparam int SERVE = 3;
  localparam int POINT = 2;
  localparam int WIN   = 3;

  logic       clk;
  logic       rst;
  logic       frame_tick;
  logic       start;
  logic       pause;
  logic [5:0] p1_score;
  logic [5:0] p2_score;
  logic       play_enable;
  logic       panel_clr;
  logic [2:0] state;
  logic [7:0] countdown;
  logic [1:0] winner;
  logic       game_over;

  int n_tests;
  int n_fail;

  // Reference model: match phase numbered as in the state encoding, frames left, last seen scores.
  int m_state;
  int m_cnt;
  int m_win;
  int m_s1;
  int m_s2;
  bit sh[3];

  pong_match_ctrl #(
    .SERVE_FRAMES(SERVE),
    .POINT_FRAMES(POINT),
    .WIN_SCORE   (WIN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .start      (start),
    .pause      (pause),
    .p1_score   (p1_score),
    .p2_score   (p2_score),
    .play_enable(play_enable),
    .panel_clr  (panel_clr),
    .state      (state),
    .countdown  (countdown),
    .winner     (winner),
    .game_over  (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    bit rise;
    if (!rst) begin
      m_state = 0;
      m_cnt   = 0;
      m_win   = 0;
      m_s1    = 0;
      m_s2    = 0;
      sh      = '{0, 0, 0};
    end else begin
      rise  = sh[1] && !sh[2];
      sh[2] = sh[1];
      sh[1] = sh[0];
      sh[0] = start;
      case (m_state)
        0, 6: if (rise) begin
          m_state = 1;
          m_win   = 0;
          m_s1    = 0;
          m_s2    = 0;
        end
        1: begin
          m_state = 2;
          m_cnt   = SERVE;
        end
        2: if (frame_tick) begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) m_state = 3;
        end
        3: begin
          if (int'(p1_score) != m_s1 || int'(p2_score) != m_s2) begin
            m_s1 = p1_score;
            m_s2 = p2_score;
            if (m_s1 >= WIN || m_s2 >= WIN) begin
              m_state = 6;
              m_win   = ((m_s1 >= WIN) ? 1 : 0) + ((m_s2 >= WIN) ? 2 : 0);
            end else begin
              m_state = 4;
              m_cnt   = POINT;
            end
          end else if (pause) begin
            m_state = 5;
          end
        end
        4: if (frame_tick) begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) begin
            m_state = 2;
            m_cnt   = SERVE;
          end
        end
        5: if (!pause) m_state = 3;
        default: m_state = 0;
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("state", int'(state), m_state);
    chk("play_enable", int'(play_enable), (m_state == 3) ? 1 : 0);
    chk("panel_clr", int'(panel_clr), (m_state == 1) ? 1 : 0);
    chk("countdown", int'(countdown), m_cnt);
    chk("winner", int'(winner), m_win);
    chk("game_over", int'(game_over), (m_state == 6) ? 1 : 0);
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  // Clock with ticks on alternate cycles until the DUT shows the target state, bounded.
  task automatic run_until(input int target, input int budget);
    int n;
    n = 0;
    while (int'(state) != target && n < budget) begin
      frame_tick = (n % 2 == 0);
      step();
      n++;
    end
    frame_tick = 1'b0;
    chk("reach_state", int'(state), target);
  endtask

  task automatic restart_to_play();
    start = 1'b0;
    repeat (3) step();
    start = 1'b1;
    run_until(1, 10);
    p1_score = 6'd0;
    p2_score = 6'd0;
    run_until(3, 20);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b0;
    start      = 1'b0;
    pause      = 1'b0;
    frame_tick = 1'b0;
    p1_score   = 6'd0;
    p2_score   = 6'd0;
    m_state    = 0;
    m_cnt      = 0;
    m_win      = 0;
    m_s1       = 0;
    m_s2       = 0;
    sh         = '{0, 0, 0};

    // Reset state
    step();
    step();
    chk("rst_state", int'(state), 0);
    chk("rst_countdown", int'(countdown), 0);
    chk("rst_winner", int'(winner), 0);
    chk("rst_game_over", int'(game_over), 0);
    rst = 1'b1;
    step();

    // Start sequence: clear pulse exactly two edges after start is first sampled
    start = 1'b1;
    step();
    chk("clr_k", int'(panel_clr), 0);
    step();
    chk("clr_k1", int'(panel_clr), 0);
    step();
    chk("clr_k2", int'(panel_clr), 1);
    chk("clear_state", int'(state), 1);
    step();
    chk("serve_state", int'(state), 2);
    chk("serve_clr", int'(panel_clr), 0);
    chk("serve_load", int'(countdown), SERVE);
    pulse_tick();
    chk("serve_dec", int'(countdown), 2);

    // Reset mid-serve
    rst   = 1'b0;
    start = 1'b0;
    step();
    chk("midrst_state", int'(state), 0);
    chk("midrst_countdown", int'(countdown), 0);
    chk("midrst_play", int'(play_enable), 0);
    chk("midrst_clr", int'(panel_clr), 0);
    rst = 1'b1;
    step();

    // Serve lasts exactly SERVE ticks; idle cycles in between do not count
    start = 1'b1;
    run_until(2, 10);
    pulse_tick();
    step();
    pulse_tick();
    step();
    chk("serve_hold", int'(state), 2);
    pulse_tick();
    chk("play_state", int'(state), 3);
    chk("play_en", int'(play_enable), 1);

    // Point
    p1_score = 6'd1;
    step();
    chk("point_state", int'(state), 4);
    chk("point_play", int'(play_enable), 0);
    pulse_tick();
    step();
    pulse_tick();
    chk("point_to_serve", int'(state), 2);
    chk("point_reload", int'(countdown), SERVE);
    run_until(3, 20);

    // Win for P2 from snapshots 2/1, start held gives no restart
    p2_score = 6'd1;
    step();
    run_until(3, 30);
    p1_score = 6'd2;
    step();
    run_until(3, 30);
    p2_score = 6'd3;
    step();
    chk("win_state", int'(state), 6);
    chk("win_p2", int'(winner), 2);
    chk("win_over", int'(game_over), 1);
    repeat (8) step();
    chk("held_start", int'(state), 6);
    start = 1'b0;
    repeat (3) step();
    start = 1'b1;
    run_until(1, 10);
    p1_score = 6'd0;
    p2_score = 6'd0;
    step();
    chk("restart_serve", int'(state), 2);
    chk("restart_winner", int'(winner), 0);

    // Simultaneous win
    run_until(3, 20);
    p1_score = 6'd2;
    step();
    run_until(3, 30);
    p2_score = 6'd2;
    step();
    run_until(3, 30);
    p1_score = 6'd3;
    p2_score = 6'd3;
    step();
    chk("both_win", int'(winner), 3);
    chk("both_state", int'(state), 6);

    // Score and pause together: point first, pause seen after next serve
    restart_to_play();
    pause    = 1'b1;
    p1_score = 6'd1;
    step();
    chk("score_over_pause", int'(state), 4);
    run_until(3, 30);
    step();
    chk("late_pause", int'(state), 5);
    chk("pause_play", int'(play_enable), 0);

    // Score changes while paused wait until play resumes
    p1_score = 6'd2;
    repeat (3) step();
    chk("paused_hold", int'(state), 5);
    pause = 1'b0;
    step();
    chk("resume", int'(state), 3);
    step();
    chk("pending_point", int'(state), 4);

    // Randomized play
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      frame_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 24) == 0) start = ~start;
      if ($urandom_range(0, 19) == 0) pause = ~pause;
      if (m_state == 1) begin
        p1_score = 6'd0;
        p2_score = 6'd0;
      end else if (m_state == 3 && $urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 2))
          0: p1_score = p1_score + 6'd1;
          1: p2_score = p2_score + 6'd1;
          default: begin
            p1_score = p1_score + 6'd1;
            p2_score = p2_score + 6'd1;
          end
        endcase
      end else if ($urandom_range(0, 99) == 0) begin
        p1_score = 6'($urandom_range(0, 5));
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
